masked_xor_pipe: RTL and testbench

- Parametrised successor of the two-share combinational XOR: bitwise XOR of two Boolean-masked operands with NS shares each, N bits per share.
- Output is produced through an elastic, valid/ready pipeline of depth STAGES.
- Each share is XORed and registered in its own datapath lane; no logic ever combines different shares.
- Used in the threshold-implementation datapath for key/round-constant addition and linear layers, where registered, share-isolated outputs are required.

---
 rtl/masked_xor_pipe.sv | 100 ++++++++++
 tb/tb_masked_xor_pipe.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/masked_xor_pipe.sv
// Share-wise XOR of two Boolean-masked operands through an elastic valid/ready pipeline.
// Optional mask refresh with fresh randomness when MASK_REFRESH_EN is defined.
module masked_xor_pipe #(
  parameter int unsigned N      = 64,
  parameter int unsigned NS     = 2,
  parameter int unsigned STAGES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NS*N-1:0]     a,
  input  logic [NS*N-1:0]     b,
`ifdef MASK_REFRESH_EN
  input  logic [(NS-1)*N-1:0] rnd,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NS*N-1:0]     out
);

  localparam int unsigned W = NS * N;

  logic [W-1:0]      mask;
  logic [W-1:0]      xor_res;
  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] load;
  logic [W-1:0]      stage_data [STAGES];

`ifdef MASK_REFRESH_EN
  // Shares 0..NS-2 take one rnd share each; the last share absorbs all of them so the
  // unmasked value is preserved.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < NS - 1; i++) begin
      mask[i*N +: N]      = rnd[i*N +: N];
      mask[(NS-1)*N +: N] = mask[(NS-1)*N +: N] ^ rnd[i*N +: N];
    end
  end
`else
  assign mask = '0;
`endif

  // Bitwise, so every result bit only sees the same bit of its own share lane.
  assign xor_res = a ^ b ^ mask;

  // A stage loads when empty or when its successor loads; out_ready feeds the last stage.
  always_comb begin
    logic nxt;
    nxt  = out_ready;
    load = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      load[k] = ~stage_valid[k] | nxt;
      nxt     = load[k];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic         src_valid;
    logic [W-1:0] src_data;
    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    if (g == 0) begin : g_head
      assign src_valid = in_valid;
      assign src_data  = xor_res;
    end else begin : g_body
      assign src_valid = stage_valid[g-1];
      assign src_data  = stage_data[g-1];
    end

    // Data only moves on a real load, so stalled or bubble stages keep their lanes quiet.
    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load[g]) begin
        valid_d = src_valid;
        if (src_valid) data_d = src_data;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end

    assign stage_valid[g] = valid_q;
    assign stage_data[g]  = data_q;
  end

  assign in_ready  = load[0];
  assign out_valid = stage_valid[STAGES-1];
  assign out       = stage_data[STAGES-1];

endmodule

// File: tb/tb_masked_xor_pipe.sv
// Scoreboard bench for masked_xor_pipe: a 2-share/1-stage and a 3-share/3-stage instance.
module tb_masked_xor_pipe;

  localparam int unsigned N  = 64;
  localparam int unsigned W1 = 2 * N;
  localparam int unsigned W3 = 3 * N;

  typedef struct {
    logic [W3-1:0] data;
    logic [W3-1:0] plain;
    int unsigned   cyc;
    bit            lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  logic          in1_valid, in1_ready, out1_valid, out1_ready;
  logic [W1-1:0] a1, b1, out1;
  logic          in3_valid, in3_ready, out3_valid, out3_ready;
  logic [W3-1:0] a3, b3, out3;
`ifdef MASK_REFRESH_EN
  logic [N-1:0]   rnd1;
  logic [2*N-1:0] rnd3;
`endif

  masked_xor_pipe #(.N(N), .NS(2), .STAGES(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in1_valid),
    .in_ready  (in1_ready),
    .a         (a1),
    .b         (b1),
`ifdef MASK_REFRESH_EN
    .rnd       (rnd1),
`endif
    .out_valid (out1_valid),
    .out_ready (out1_ready),
    .out       (out1)
  );

  masked_xor_pipe #(.N(N), .NS(3), .STAGES(3)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in3_valid),
    .in_ready  (in3_ready),
    .a         (a3),
    .b         (b3),
`ifdef MASK_REFRESH_EN
    .rnd       (rnd3),
`endif
    .out_valid (out3_valid),
    .out_ready (out3_ready),
    .out       (out3)
  );

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1a, e1m, e3a, e3m;
  int   acc3 = 0;
  int   del3 = 0;
  bit   lat_chk3 = 1'b0;
  bit   stall3 = 1'b0;
  logic [W3-1:0] held3;

  task automatic check(input string name, input logic [W3-1:0] act, input logic [W3-1:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic logic [N-1:0] unmask3(input logic [W3-1:0] v);
    return v[N-1:0] ^ v[2*N-1:N] ^ v[3*N-1:2*N];
  endfunction

  function automatic logic [W3-1:0] mask3(input logic [2*N-1:0] r);
    return {r[N-1:0] ^ r[2*N-1:N], r[2*N-1:N], r[N-1:0]};
  endfunction

  // Input-side scoreboard: a transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && in1_valid && in1_ready) begin
      e1a.plain = W3'(a1 ^ b1);
      e1a.data  = e1a.plain;
      e1a.cyc   = cyc;
      e1a.lat   = 1'b1;
      q1.push_back(e1a);
    end
    if (rst_n && in3_valid && in3_ready) begin
      e3a.plain = a3 ^ b3;
`ifdef MASK_REFRESH_EN
      e3a.data  = e3a.plain ^ mask3(rnd3);
`else
      e3a.data  = e3a.plain;
`endif
      e3a.cyc   = cyc;
      e3a.lat   = lat_chk3;
      q3.push_back(e3a);
      acc3++;
    end
  end

  always @(negedge clk) begin
    if (rst_n && out1_valid && out1_ready) begin
      if (q1.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_beat1: got %h required none", out1);
      end else begin
        e1m = q1.pop_front();
        check("data1", W3'(out1), e1m.data);
        check("latency1", W3'(cyc - e1m.cyc), W3'(1));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      stall3 = 1'b0;
    end else begin
      if (stall3) begin
        check("hold_valid3", W3'(out3_valid), W3'(1));
        check("hold_data3", out3, held3);
      end
      stall3 = out3_valid && !out3_ready;
      held3  = out3;
      if (out3_valid && out3_ready) begin
        if (q3.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_beat3: got %h required none", out3);
        end else begin
          e3m = q3.pop_front();
          check("data3", out3, e3m.data);
          if (e3m.lat) check("latency3", W3'(cyc - e3m.cyc), W3'(3));
`ifdef MASK_REFRESH_EN
          check("unmasked3", W3'(unmask3(out3)), W3'(unmask3(e3m.plain)));
`endif
          del3++;
        end
      end
    end
  end

  task automatic send1(input logic [W1-1:0] va, input logic [W1-1:0] vb);
    int unsigned waits;
    waits = 0;
    in1_valid = 1'b1;
    a1 = va;
    b1 = vb;
    @(negedge clk);
    while (!in1_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!in1_ready) begin
      compared++;
      mismatched++;
      $display("FAIL send1_timeout: got no in_ready required in_ready within 50 cycles");
    end
    @(posedge clk);
    #1;
    in1_valid = 1'b0;
  endtask

  task automatic send3(input logic [W3-1:0] va, input logic [W3-1:0] vb,
                       input logic [2*N-1:0] vr, output int unsigned waits);
    waits = 0;
    in3_valid = 1'b1;
    a3 = va;
    b3 = vb;
`ifdef MASK_REFRESH_EN
    rnd3 = vr;
`endif
    @(negedge clk);
    while (!in3_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!in3_ready) begin
      compared++;
      mismatched++;
      $display("FAIL send3_timeout: got no in_ready required in_ready within 50 cycles");
    end
    @(posedge clk);
    #1;
    in3_valid = 1'b0;
  endtask

  task automatic drain3();
    int unsigned n;
    n = 0;
    while (q3.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q3.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain3: got %0d pending required 0", q3.size());
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W3-1:0] vec_a(input int unsigned i);
    return {64'h0123_4567_89AB_CDEF + 64'(i), 64'hDEAD_BEEF_0000_0000 | 64'(i),
            ~(64'h1 << i)};
  endfunction

  function automatic logic [W3-1:0] vec_b(input int unsigned i);
    return {64'hFFFF_0000_FFFF_0000 ^ 64'(i * 7), 64'h5555_AAAA_5555_AAAA, 64'(i) << 32};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned w, tw;
    in1_valid = 1'b0; out1_ready = 1'b1; a1 = '0; b1 = '0;
    in3_valid = 1'b0; out3_ready = 1'b1; a3 = '0; b3 = '0;
`ifdef MASK_REFRESH_EN
    rnd1 = '0; rnd3 = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid3", W3'(out3_valid), W3'(0));
    check("rst_out3", out3, W3'(0));
    check("rst_out_valid1", W3'(out1_valid), W3'(0));
    check("rst_out1", W3'(out1), W3'(0));
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready3", W3'(in3_ready), W3'(1));
    check("rst_in_ready1", W3'(in1_ready), W3'(1));

    // Hand-computed single beat, 2 shares, 1 stage.
    @(posedge clk);
    #1;
    send1({64'h0F0F_0F0F_0F0F_0F0F, 64'h1234_5678_9ABC_DEF0},
          {64'hFFFF_FFFF_0000_0000, 64'h1111_1111_1111_1111});
    @(negedge clk);
    check("single_valid", W3'(out1_valid), W3'(1));
    check("single_data", W3'(out1), W3'({64'hF0F0_F0F0_0F0F_0F0F, 64'h0325_4769_8BAD_CFE1}));
    @(negedge clk);
    check("single_once", W3'(out1_valid), W3'(0));

    // Streaming: 8 back-to-back beats, no stalls.
    @(posedge clk);
    #1;
    lat_chk3 = 1'b1;
    tw = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      send3(vec_a(i), vec_b(i), '0, w);
      tw += w;
    end
    check("stream_in_ready", W3'(tw), W3'(0));
    lat_chk3 = 1'b0;
    drain3();

    // Backpressure fill, then simultaneous accept and drain on a full pipeline.
    out3_ready = 1'b0;
    tw = 0;
    for (int unsigned i = 8; i < 11; i++) begin
      send3(vec_a(i), vec_b(i), '0, w);
      tw += w;
    end
    check("bp_fill_no_wait", W3'(tw), W3'(0));
    check("bp_in_ready_low", W3'(in3_ready), W3'(0));
    check("bp_occupancy", W3'(acc3 - del3), W3'(3));
    in3_valid = 1'b1;
    a3 = vec_a(11);
    b3 = vec_b(11);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_stall_in_ready", W3'(in3_ready), W3'(0));
    end
    out3_ready = 1'b1;
    #1;
    check("full_sim_in_ready", W3'(in3_ready), W3'(1));
    check("full_sim_out_valid", W3'(out3_valid), W3'(1));
    @(posedge clk);
    #1;
    in3_valid = 1'b0;
    check("full_sim_occupancy", W3'(acc3 - del3), W3'(3));
    check("full_sim_still_valid", W3'(out3_valid), W3'(1));
    drain3();

    // Reset during a 3-beat burst discards everything in flight.
    send3(vec_a(12), vec_b(12), '0, w);
    send3(vec_a(13), vec_b(13), '0, w);
    in3_valid = 1'b1;
    a3 = vec_a(14);
    b3 = vec_b(14);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    in3_valid = 1'b0;
    q3.delete();
    acc3 = 0;
    del3 = 0;
    check("midrst_out_valid", W3'(out3_valid), W3'(0));
    check("midrst_out", out3, W3'(0));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", W3'(in3_ready), W3'(1));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst_no_stale", W3'(out3_valid), W3'(0));
    end

`ifdef MASK_REFRESH_EN
    // Refresh: random operands and randomness, 3 shares.
    @(posedge clk);
    #1;
    lat_chk3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send3({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom}, w);
    end
    lat_chk3 = 1'b0;
    drain3();
`endif

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
